// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: RV32I funct3 width
// codes, FSM state encoding and small decode helpers.
package lsu_pkg;

   localparam logic [2:0] LSU_B  = 3'b000;
   localparam logic [2:0] LSU_H  = 3'b001;
   localparam logic [2:0] LSU_W  = 3'b010;
   localparam logic [2:0] LSU_BU = 3'b100;
   localparam logic [2:0] LSU_HU = 3'b101;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_STORE  = 3'd2,
      ST_RMW_RD = 3'd3,
      ST_RMW_WR = 3'd4,
      ST_RESP   = 3'd5
   } lsu_state_t;

   // Access size in bytes; only meaningful for legal funct3 codes.
   function automatic logic [2:0] lsu_size(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   lsu_size = 3'd1;
         2'b01:   lsu_size = 3'd2;
         default: lsu_size = 3'd4;
      endcase
   endfunction

   function automatic logic lsu_f3_legal(input logic we, input logic [2:0] f3);
      if (we) begin
         lsu_f3_legal = (f3 == LSU_B) || (f3 == LSU_H) || (f3 == LSU_W);
      end else begin
         lsu_f3_legal = (f3 == LSU_B) || (f3 == LSU_H) || (f3 == LSU_W) ||
                        (f3 == LSU_BU) || (f3 == LSU_HU);
      end
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: extracts and extends load data from a memory word, and
// merges sub-word store data into an old word for read-modify-write.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] ld_word,
   input  logic [1:0]      off,
   input  logic [2:0]      f3,
   input  logic [XLEN-1:0] st_old,
   input  logic [XLEN-1:0] st_wdata,
   output logic [XLEN-1:0] ld_data,
   output logic [XLEN-1:0] st_word
);

   logic [XLEN-1:0] shifted;

   always_comb begin : load_extract
      shifted = ld_word >> {off, 3'b000};
      case (f3)
         LSU_B:   ld_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         LSU_H:   ld_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         LSU_BU:  ld_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
         LSU_HU:  ld_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
         default: ld_data = shifted;
      endcase
   end

   // Halfword lane is chosen by off[1] alone; alignment was enforced upstream.
   always_comb begin : store_merge
      st_word = st_old;
      case (f3[1:0])
         2'b00:   st_word[{off, 3'b000} +: 8]         = st_wdata[7:0];
         2'b01:   st_word[{off[1], 4'b0000} +: 16]    = st_wdata[15:0];
         default: st_word                             = st_wdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit driving a word-wide data memory without byte
// enables; sub-word stores go through a read-modify-write sequence.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int MEM_BYTES = 1024
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_rdata,
   output logic            resp_misaligned,
   output logic            resp_illegal,
   output logic            resp_fault,
   output logic            MemWrite,
   output logic            MemRead,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata,
   output lsu_state_t      dbg_state
);

   // Handshake: a request transfers on a rising edge where req_valid and
   // req_ready are both 1; req_ready is 1 only in IDLE, and the core holds
   // every request field stable until that edge. resp_valid is a single-cycle
   // pulse carrying rdata and the error flags.

   lsu_state_t      state_q, state_d;
   logic [2:0]      f3_q, f3_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [XLEN-1:0] old_q, old_d;
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic            mis_q, mis_d;
   logic            ill_q, ill_d;
   logic            flt_q, flt_d;

   logic [2:0]      acc_size;
   logic [XLEN:0]   last_byte;
   logic            acc_ill, acc_mis, acc_flt;
   logic [XLEN-1:0] ld_data, st_word;

   // Extra top bit keeps the end-of-access sum from wrapping near 2^XLEN.
   always_comb begin : accept_checks
      acc_size  = lsu_size(req_funct3);
      last_byte = {1'b0, req_addr} + (XLEN+1)'(acc_size) - (XLEN+1)'(1);
      acc_ill   = !lsu_f3_legal(req_we, req_funct3);
      acc_mis   = !acc_ill &&
                  (((acc_size == 3'd2) && req_addr[0]) ||
                   ((acc_size == 3'd4) && (req_addr[1:0] != 2'b00)));
      acc_flt   = !acc_ill && !acc_mis && (last_byte >= (XLEN+1)'(MEM_BYTES));
   end

   lsu_align #(.XLEN(XLEN)) u_align (
      .ld_word  (mem_rdata),
      .off      (addr_q[1:0]),
      .f3       (f3_q),
      .st_old   (old_q),
      .st_wdata (wdata_q),
      .ld_data  (ld_data),
      .st_word  (st_word)
   );

   always_comb begin : fsm_next
      state_d         = state_q;
      f3_d            = f3_q;
      addr_d          = addr_q;
      wdata_d         = wdata_q;
      old_d           = old_q;
      rdata_d         = rdata_q;
      mis_d           = mis_q;
      ill_d           = ill_q;
      flt_d           = flt_q;
      req_ready       = 1'b0;
      resp_valid      = 1'b0;
      resp_rdata      = '0;
      resp_misaligned = 1'b0;
      resp_illegal    = 1'b0;
      resp_fault      = 1'b0;
      MemRead         = 1'b0;
      MemWrite        = 1'b0;
      mem_wdata       = '0;

      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               f3_d    = req_funct3;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               rdata_d = '0;
               ill_d   = acc_ill;
               mis_d   = acc_mis;
               flt_d   = acc_flt;
               if (acc_ill || acc_mis || acc_flt) begin
                  state_d = ST_RESP;
               end else if (!req_we) begin
                  state_d = ST_LOAD;
               end else if (req_funct3 == LSU_W) begin
                  state_d = ST_STORE;
               end else begin
                  state_d = ST_RMW_RD;
               end
            end
         end
         ST_LOAD: begin
            MemRead = 1'b1;
            rdata_d = ld_data;
            state_d = ST_RESP;
         end
         ST_STORE: begin
            MemWrite  = 1'b1;
            mem_wdata = wdata_q;
            state_d   = ST_RESP;
         end
         ST_RMW_RD: begin
            MemRead = 1'b1;
            old_d   = mem_rdata;
            state_d = ST_RMW_WR;
         end
         ST_RMW_WR: begin
            MemWrite  = 1'b1;
            mem_wdata = st_word;
            state_d   = ST_RESP;
         end
         ST_RESP: begin
            resp_valid      = 1'b1;
            resp_rdata      = rdata_q;
            resp_misaligned = mis_q;
            resp_illegal    = ill_q;
            resp_fault      = flt_q;
            state_d         = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         old_q   <= '0;
         rdata_q <= '0;
         mis_q   <= 1'b0;
         ill_q   <= 1'b0;
         flt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         old_q   <= old_d;
         rdata_q <= rdata_d;
         mis_q   <= mis_d;
         ill_q   <= ill_d;
         flt_q   <= flt_d;
      end
   end

   assign mem_addr  = {addr_q[XLEN-1:2], 2'b00};
   assign dbg_state = state_q;

endmodule
